// File: rtl/dmi_access_ctrl_if.sv
// DMI request/response bundle between the DTM access controller and the DM.
// master = DTM-side controller, slave = debug module.
interface dmi_access_ctrl_if #(
    parameter int AbitsDmi = 7
) ();
    logic                req_valid;
    logic                req_ready;
    logic [AbitsDmi-1:0] req_addr;
    logic [1:0]          req_op;
    logic [31:0]         req_data;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_data;
    logic [1:0]          resp_resp;

    modport master (
        output req_valid,
        output req_addr,
        output req_op,
        output req_data,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_resp
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_op,
        input  req_data,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_resp
    );
endinterface

// File: rtl/dmi_access_ctrl.sv
// DTM-side DMI access controller: one outstanding DMI transaction, sticky dmistat.
// Optional response watchdog enabled by defining DMI_ACC_TIMEOUT_EN.
module dmi_access_ctrl #(
    parameter int AbitsDmi      = 7,
    parameter int TimeoutCycles = 1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                update_i,
    input  logic [1:0]          update_op_i,
    input  logic [AbitsDmi-1:0] update_addr_i,
    input  logic [31:0]         update_data_i,
    input  logic                capture_i,
    output logic [1:0]          capture_op_o,
    output logic [AbitsDmi-1:0] capture_addr_o,
    output logic [31:0]         capture_data_o,
    input  logic                dmireset_i,
    input  logic                dmihardreset_i,
    output logic [1:0]          dmistat_o,
    output logic                dmi_rst_no,
    dmi_access_ctrl_if.master   dmi
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;
    localparam logic [1:0] ErrFail = 2'd2;
    localparam logic [1:0] ErrBusy = 2'd3;

    state_e              state_q;
    state_e              state_n;
    logic [AbitsDmi-1:0] addr_q;
    logic [1:0]          op_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [1:0]          error_q;
    logic [1:0]          error_n;
    logic [1:0]          err_base;
    logic                rst_n_q;
    logic                is_idle;
    logic                op_ok;
    logic                accept;
    logic                req_hs;
    logic                resp_hs;
    logic                busy_evt;
    logic                timeout;
    logic                timeout_fire;

    assign is_idle  = (state_q == IDLE);
    assign err_base = dmireset_i ? 2'd0 : error_q;
    assign op_ok    = (update_op_i == OpRead) || (update_op_i == OpWrite);
    assign accept   = update_i && is_idle && op_ok
                    && (err_base == 2'd0) && !dmihardreset_i;
    assign req_hs   = (state_q == REQ) && dmi.req_ready;
    assign resp_hs  = (state_q == WAIT) && dmi.resp_valid;
    assign busy_evt = !is_idle && (update_i || capture_i);
    assign timeout_fire = timeout && !req_hs && !resp_hs;

`ifdef DMI_ACC_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;

    assign timeout = !is_idle
                   && (cnt_q == CntW'(TimeoutCycles - 1));

    // Watchdog counts cycles spent in the current REQ/WAIT visit.
    always_ff @(posedge clk_i) begin
        if (rst_i || dmihardreset_i || is_idle || (state_n != state_q))
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end
`else
    // Without the watchdog the controller waits for the DM forever.
    assign timeout = 1'b0 & (TimeoutCycles == 0);
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    // Next-state logic; hard reset dominates everything.
    always_comb begin
        state_n = state_q;
        if (dmihardreset_i) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_n = REQ;
                REQ: begin
                    if (req_hs)
                        state_n = WAIT;
                    else if (timeout)
                        state_n = IDLE;
                end
                WAIT: begin
                    if (dmi.resp_valid)
                        state_n = IDLE;
                    else if (timeout)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        dmi.req_valid  = (state_q == REQ);
        dmi.resp_ready = (state_q == WAIT);
    end

    assign dmi.req_addr = addr_q;
    assign dmi.req_op   = op_q;
    assign dmi.req_data = wdata_q;

    // Sticky error: dmireset clears first, then only the first new error lands.
    always_comb begin
        error_n = err_base;
        if (resp_hs && (dmi.resp_resp != 2'd0) && (error_n == 2'd0))
            error_n = dmi.resp_resp;
        if (busy_evt && (error_n == 2'd0))
            error_n = ErrBusy;
        if (timeout_fire && (error_n == 2'd0))
            error_n = ErrFail;
        if (dmihardreset_i)
            error_n = 2'd0;
    end

    // Error register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            error_q <= 2'd0;
        else
            error_q <= error_n;
    end

    // Request latch on an accepted update; read data on a read response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            op_q    <= 2'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                addr_q  <= update_addr_i;
                op_q    <= update_op_i;
                wdata_q <= update_data_i;
            end
            if (resp_hs && (op_q == OpRead) && !dmihardreset_i)
                rdata_q <= dmi.resp_data;
        end
    end

    // Capture-DR snapshot taken from pre-update state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            capture_op_o   <= 2'd0;
            capture_addr_o <= '0;
            capture_data_o <= 32'd0;
        end else if (capture_i && !dmihardreset_i) begin
            capture_op_o   <= is_idle ? error_q : ErrBusy;
            capture_addr_o <= addr_q;
            capture_data_o <= rdata_q;
        end
    end

    // DMI reset to the DM: low in reset and for one cycle after a hard reset.
    always_ff @(posedge clk_i) begin
        rst_n_q <= !(rst_i || dmihardreset_i);
    end

    assign dmi_rst_no = rst_n_q;
    assign dmistat_o  = error_q;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Directed self-checking bench for dmi_access_ctrl.
// Expected values are hand-derived cycle by cycle.
module tb_dmi_access_ctrl;

`ifdef DMI_ACC_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        clk;
    logic        rst;
    logic        update;
    logic [1:0]  update_op;
    logic [6:0]  update_addr;
    logic [31:0] update_data;
    logic        capture;
    logic [1:0]  capture_op;
    logic [6:0]  capture_addr;
    logic [31:0] capture_data;
    logic        dmireset;
    logic        dmihardreset;
    logic [1:0]  dmistat;
    logic        dmi_rst_n;

    int tests = 0;
    int fails = 0;

    dmi_access_ctrl_if #(.AbitsDmi(7)) dmi ();

    dmi_access_ctrl #(
        .AbitsDmi      (7),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .update_i       (update),
        .update_op_i    (update_op),
        .update_addr_i  (update_addr),
        .update_data_i  (update_data),
        .capture_i      (capture),
        .capture_op_o   (capture_op),
        .capture_addr_o (capture_addr),
        .capture_data_o (capture_data),
        .dmireset_i     (dmireset),
        .dmihardreset_i (dmihardreset),
        .dmistat_o      (dmistat),
        .dmi_rst_no     (dmi_rst_n),
        .dmi            (dmi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [1:0] op, input logic [6:0] a,
                       input logic [31:0] d);
        update      = 1'b1;
        update_op   = op;
        update_addr = a;
        update_data = d;
    endtask

    initial begin
        rst = 1'b1; update = 1'b0; update_op = 2'd0;
        update_addr = 7'd0; update_data = 32'd0;
        capture = 1'b0; dmireset = 1'b0; dmihardreset = 1'b0;
        dmi.req_ready = 1'b0; dmi.resp_valid = 1'b0;
        dmi.resp_data = 32'd0; dmi.resp_resp = 2'd0;

        // reset
        tick(); tick();
        chk("rst_dmi_rst_n", 32'(dmi_rst_n), 32'd0);
        chk("rst_req_valid", 32'(dmi.req_valid), 32'd0);
        chk("rst_resp_ready", 32'(dmi.resp_ready), 32'd0);
        chk("rst_dmistat", 32'(dmistat), 32'd0);
        chk("rst_cap_op", 32'(capture_op), 32'd0);
        chk("rst_cap_data", capture_data, 32'd0);
        rst = 1'b0;
        tick();
        chk("rel_dmi_rst_n", 32'(dmi_rst_n), 32'd1);

        // write then read at minimum latency
        dmi.req_ready = 1'b1; dmi.resp_valid = 1'b1;
        upd(2'd2, 7'h04, 32'hDEADBEEF);
        tick(); update = 1'b0;
        chk("wr_req_valid", 32'(dmi.req_valid), 32'd1);
        chk("wr_req_addr", 32'(dmi.req_addr), 32'h04);
        chk("wr_req_op", 32'(dmi.req_op), 32'd2);
        chk("wr_req_data", dmi.req_data, 32'hDEADBEEF);
        tick();
        chk("wr_resp_ready", 32'(dmi.resp_ready), 32'd1);
        chk("wr_wait_valid", 32'(dmi.req_valid), 32'd0);
        tick();
        chk("wr_idle_ready", 32'(dmi.resp_ready), 32'd0);
        dmi.resp_data = 32'hDEADBEEF;
        upd(2'd1, 7'h04, 32'd0);
        tick(); update = 1'b0;
        chk("rd_req_op", 32'(dmi.req_op), 32'd1);
        tick(); tick();
        capture = 1'b1;
        tick(); capture = 1'b0;
        chk("rd_cap_op", 32'(capture_op), 32'd0);
        chk("rd_cap_data", capture_data, 32'hDEADBEEF);
        chk("rd_cap_addr", 32'(capture_addr), 32'h04);
        chk("rd_dmistat", 32'(dmistat), 32'd0);

        // busy capture and busy update
        dmi.req_ready = 1'b0; dmi.resp_valid = 1'b0;
        upd(2'd1, 7'h08, 32'd0);
        tick(); update = 1'b0;
        tick();
        capture = 1'b1;
        tick(); capture = 1'b0;
        chk("busy_cap_op", 32'(capture_op), 32'd3);
        chk("busy_dmistat", 32'(dmistat), 32'd3);
        upd(2'd2, 7'h10, 32'h55);
        tick(); update = 1'b0;
        chk("busy_hold_valid", 32'(dmi.req_valid), 32'd1);
        chk("busy_hold_addr", 32'(dmi.req_addr), 32'h08);
        chk("busy_hold_op", 32'(dmi.req_op), 32'd1);
        tick();
        dmi.req_ready = 1'b1;
        tick(); dmi.req_ready = 1'b0;
        dmi.resp_valid = 1'b1; dmi.resp_data = 32'h1234;
        tick(); dmi.resp_valid = 1'b0;
        chk("busy_done_ready", 32'(dmi.resp_ready), 32'd0);
        tick();
        chk("busy_no_second", 32'(dmi.req_valid), 32'd0);
        chk("busy_sticky", 32'(dmistat), 32'd3);
        dmireset = 1'b1;
        tick(); dmireset = 1'b0;
        chk("busy_cleared", 32'(dmistat), 32'd0);

        // DM error response blocks further requests
        dmi.req_ready = 1'b1; dmi.resp_valid = 1'b1;
        dmi.resp_resp = 2'd2; dmi.resp_data = 32'h0BAD0BAD;
        upd(2'd1, 7'h11, 32'd0);
        tick(); update = 1'b0;
        tick(); tick();
        chk("err_dmistat", 32'(dmistat), 32'd2);
        dmi.resp_resp = 2'd0;
        upd(2'd1, 7'h12, 32'd0);
        tick(); update = 1'b0;
        chk("err_blocked", 32'(dmi.req_valid), 32'd0);
        tick();
        chk("err_blocked2", 32'(dmi.req_valid), 32'd0);
        capture = 1'b1;
        tick(); capture = 1'b0;
        chk("err_cap_op", 32'(capture_op), 32'd2);
        chk("err_cap_addr", 32'(capture_addr), 32'h11);
        chk("err_cap_data", capture_data, 32'h0BAD0BAD);
        dmireset = 1'b1;
        tick(); dmireset = 1'b0;
        chk("err_cleared", 32'(dmistat), 32'd0);
        dmi.resp_data = 32'hCAFEF00D;
        upd(2'd1, 7'h12, 32'd0);
        tick(); update = 1'b0;
        chk("err_retry_valid", 32'(dmi.req_valid), 32'd1);
        chk("err_retry_addr", 32'(dmi.req_addr), 32'h12);
        tick(); tick();
        chk("err_retry_done", 32'(dmi.resp_ready), 32'd0);

        // hard reset while waiting for a response
        dmi.resp_valid = 1'b0;
        upd(2'd1, 7'h20, 32'd0);
        tick(); update = 1'b0;
        tick();
        chk("hr_waiting", 32'(dmi.resp_ready), 32'd1);
        capture = 1'b1;
        tick(); capture = 1'b0;
        chk("hr_pre_err", 32'(dmistat), 32'd3);
        dmihardreset = 1'b1;
        tick(); dmihardreset = 1'b0;
        chk("hr_rst_low", 32'(dmi_rst_n), 32'd0);
        chk("hr_ready_low", 32'(dmi.resp_ready), 32'd0);
        chk("hr_dmistat", 32'(dmistat), 32'd0);
        dmi.resp_valid = 1'b1; dmi.resp_data = 32'h0BAD;
        tick(); dmi.resp_valid = 1'b0;
        chk("hr_rst_high", 32'(dmi_rst_n), 32'd1);
        chk("hr_late_ready", 32'(dmi.resp_ready), 32'd0);
        chk("hr_late_valid", 32'(dmi.req_valid), 32'd0);
        capture = 1'b1;
        tick(); capture = 1'b0;
        chk("hr_cap_data", capture_data, 32'hCAFEF00D);
        chk("hr_cap_addr", 32'(capture_addr), 32'h20);
        chk("hr_cap_op", 32'(capture_op), 32'd0);

        // dmireset together with update while error is 3
        dmi.req_ready = 1'b0;
        upd(2'd1, 7'h2A, 32'd0);
        tick(); update = 1'b0;
        capture = 1'b1;
        tick(); capture = 1'b0;
        chk("sim_pre_err", 32'(dmistat), 32'd3);
        dmi.req_ready = 1'b1;
        tick(); dmi.req_ready = 1'b0;
        dmi.resp_valid = 1'b1; dmi.resp_data = 32'h77;
        tick(); dmi.resp_valid = 1'b0;
        dmireset = 1'b1;
        upd(2'd1, 7'h30, 32'd0);
        tick(); dmireset = 1'b0; update = 1'b0;
        chk("sim_req_valid", 32'(dmi.req_valid), 32'd1);
        chk("sim_req_addr", 32'(dmi.req_addr), 32'h30);
        chk("sim_dmistat", 32'(dmistat), 32'd0);
        dmi.req_ready = 1'b1;
        tick(); dmi.req_ready = 1'b0;
        dmi.resp_valid = 1'b1; dmi.resp_data = 32'h99;
        tick(); dmi.resp_valid = 1'b0;
        chk("sim_done", 32'(dmi.req_valid), 32'd0);

        // capture together with update samples pre-update state
        capture = 1'b1;
        upd(2'd2, 7'h31, 32'hA5A5A5A5);
        tick(); capture = 1'b0; update = 1'b0;
        chk("cu_cap_addr", 32'(capture_addr), 32'h30);
        chk("cu_cap_data", capture_data, 32'h99);
        chk("cu_cap_op", 32'(capture_op), 32'd0);
        chk("cu_req_addr", 32'(dmi.req_addr), 32'h31);
        chk("cu_req_data", dmi.req_data, 32'hA5A5A5A5);
        dmi.req_ready = 1'b1;
        tick(); dmi.req_ready = 1'b0;
        dmi.resp_valid = 1'b1;
        tick(); dmi.resp_valid = 1'b0;

        // reserved op creates no request and latches nothing
        upd(2'd3, 7'h7F, 32'd0);
        tick(); update = 1'b0;
        chk("nop_no_req", 32'(dmi.req_valid), 32'd0);
        capture = 1'b1;
        tick(); capture = 1'b0;
        chk("nop_cap_addr", 32'(capture_addr), 32'h31);

        // DM never ready: watchdog (if built in) or indefinite wait
        upd(2'd1, 7'h40, 32'd0);
        tick(); update = 1'b0;
        chk("to_valid_c1", 32'(dmi.req_valid), 32'd1);
        repeat (15) tick();
        chk("to_valid_c16", 32'(dmi.req_valid), 32'd1);
        tick();
`ifdef DMI_ACC_TIMEOUT_EN
        chk("to_valid_c17", 32'(dmi.req_valid), 32'd0);
        chk("to_dmistat", 32'(dmistat), 32'd2);
        dmi.resp_valid = 1'b1;
        tick(); dmi.resp_valid = 1'b0;
        chk("to_late_ready", 32'(dmi.resp_ready), 32'd0);
`else
        chk("to_valid_c17", 32'(dmi.req_valid), 32'd1);
        chk("to_dmistat", 32'(dmistat), 32'd0);
        dmi.req_ready = 1'b1;
        tick(); dmi.req_ready = 1'b0;
        dmi.resp_valid = 1'b1;
        tick(); dmi.resp_valid = 1'b0;
        chk("to_done", 32'(dmi.resp_ready), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
